jtopl_pg_acc: RTL

//  Phase accumulator stage of the phase generator, downstream of the phinc calculation.
//  - Takes the per-slot pure phase increment (17 b), applies the MULT factor and

---
 rtl/jtopl_pg_pkg.sv | 30 +++
 rtl/jtopl_pg_mul.sv | 31 +++
 rtl/jtopl_pg_acc.sv | 127 ++++++++++++
 3 files changed

// File: rtl/jtopl_pg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package  : jtopl_pg_pkg                                               |
// | Purpose  : Shared widths, MULT table and types for the phase          |
// |            accumulator stage of the phase generator.                  |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package jtopl_pg_pkg;

  // Operator slots in the time-multiplexed ring (fixed by the chip)
  localparam int SLOTS   = 18;
  // Accumulator: 10 integer bits + 9 fraction bits
  localparam int PHW     = 19;
  localparam int PHINC_W = 17;
  localparam int PHOUT_W = 10;
  localparam int SLOT_W  = 5;
  localparam int MUL_W   = 4;

  // MULT factor per register value; entry 0 is unused because mul==0 halves
  localparam logic [MUL_W-1:0] MT [16] = '{
    4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
    4'd8,  4'd9,  4'd10, 4'd10, 4'd12, 4'd12, 4'd15, 4'd15
  };

  typedef logic [PHW-1:0]     phase_t;
  typedef logic [PHINC_W-1:0] phinc_t;
  typedef logic [SLOT_W-1:0]  slot_t;

endpackage
`default_nettype wire

// File: rtl/jtopl_pg_mul.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : jtopl_pg_mul                                               |
// | Purpose  : Scales the pure phase increment by the MULT factor.        |
// |            mul==0 halves the increment; otherwise the 21-bit product  |
// |            is truncated to the accumulator width.                     |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module jtopl_pg_mul
  import jtopl_pg_pkg::*;
(
  input  logic [PHINC_W-1:0] phinc_pure,
  input  logic [MUL_W-1:0]   mul,
  output logic [PHW-1:0]     phinc_mul
);

  localparam int PROD_W = PHINC_W + MUL_W;

  logic [PROD_W-1:0] product;

  // Full-width product, then select halving or truncated product
  always_comb begin
    product   = PROD_W'(phinc_pure) * PROD_W'(MT[mul]);
    phinc_mul = product[PHW-1:0];
    if (mul == '0) begin
      phinc_mul = {{(PHW-PHINC_W+1){1'b0}}, phinc_pure[PHINC_W-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtopl_pg_acc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : jtopl_pg_acc                                               |
// | Purpose  : Two-stage phase accumulator for 18 time-multiplexed        |
// |            operator slots. S1 scales the increment, S2 adds it to     |
// |            the slot's stored phase held in an 18-entry shift ring.    |
// | Options  : JTOPL_PG_FREEZE_EN adds pg_freeze, which holds every       |
// |            slot's phase while asserted.                               |
// | Revision : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module jtopl_pg_acc
  import jtopl_pg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  input  logic               zero,
  input  logic [PHINC_W-1:0] phinc_pure,
  input  logic [MUL_W-1:0]   mul,
  input  logic               keyon_I,
`ifdef JTOPL_PG_FREEZE_EN
  input  logic               pg_freeze,
`endif
  output logic [PHOUT_W-1:0] phase_op,
  output logic [SLOT_W-1:0]  slot_o
);

  logic   freeze_in;
  slot_t  cnt;
  slot_t  cnt_eff;
  slot_t  cnt_next;
  phase_t phinc_calc;

  // S1 registers
  phase_t s1_phinc;
  logic   s1_keyon;
  logic   s1_freeze;
  slot_t  s1_slot;

  // Ring: ring[0] receives the S2 result, ring[SLOTS-1] feeds S2.
  // Writing into ring[0] while reading ring[SLOTS-1] closes a loop of
  // exactly SLOTS cen cycles.
  phase_t ring [SLOTS];
  phase_t stored;
  phase_t next_phase;

`ifdef JTOPL_PG_FREEZE_EN
  assign freeze_in = pg_freeze;
`else
  assign freeze_in = 1'b0;
`endif

  jtopl_pg_mul u_mul (
    .phinc_pure (phinc_pure),
    .mul        (mul),
    .phinc_mul  (phinc_calc)
  );

  // Input-side slot number: zero forces slot 0 and takes priority over wrap
  always_comb begin
    cnt_eff  = zero ? '0 : cnt;
    cnt_next = (cnt_eff == SLOT_W'(SLOTS-1)) ? '0 : cnt_eff + 1'b1;
  end

  // Slot counter advances once per cen cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cen) begin
      cnt <= cnt_next;
    end
  end

  // S1: capture scaled increment and per-slot controls alongside the slot index.
  // Freeze travels with the slot's inputs so it applies to the same slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_phinc  <= '0;
      s1_keyon  <= 1'b0;
      s1_freeze <= 1'b0;
      s1_slot   <= '0;
    end else if (cen) begin
      s1_phinc  <= phinc_calc;
      s1_keyon  <= keyon_I;
      s1_freeze <= freeze_in;
      s1_slot   <= cnt_eff;
    end
  end

  // S2 adder: freeze wins over key-on; overflow wraps without saturation
  always_comb begin
    stored     = ring[SLOTS-1];
    next_phase = stored + s1_phinc;
    if (s1_freeze) begin
      next_phase = stored;
    end else if (s1_keyon) begin
      next_phase = '0;
    end
  end

  // Phase ring rotates one place per cen cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        ring[i] <= '0;
      end
    end else if (cen) begin
      ring[0] <= next_phase;
      for (int i = 1; i < SLOTS; i++) begin
        ring[i] <= ring[i-1];
      end
    end
  end

  // S2 outputs: integer part of the new phase and its slot index
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_op <= '0;
      slot_o   <= '0;
    end else if (cen) begin
      phase_op <= next_phase[PHW-1:PHW-PHOUT_W];
      slot_o   <= s1_slot;
    end
  end

endmodule
`default_nettype wire
